bsg_manycore_host_word_gearbox: RTL and testbench

Width gearbox between a 32-bit host word port and the fifo_width_p-bit aligned manycore packet streams of the endpoint FIFO bridge. The TX path packs host words into one request packet; the RX path unpacks one response or request packet into host words. Each path holds one packet and exposes word-level occupancy for host polling. Sits between the host MMIO/AXI-Lite word registers and the endpoint FIFO bridge.

---
 rtl/bsg_manycore_host_word_gearbox.sv | 132 +++++++++++++
 tb/tb_bsg_manycore_host_word_gearbox.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_host_word_gearbox.sv
`default_nettype none
// ============================================================================
// Module   : bsg_manycore_host_word_gearbox
// Purpose  : Packs 32-bit host words into aligned manycore packets (TX) and
//            unpacks incoming packets into host words (RX).
// Revision : 1.0
// ============================================================================
module bsg_manycore_host_word_gearbox #(
    parameter int fifo_width_p = 128,
    parameter int host_width_p = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,

    input  logic [host_width_p-1:0] tx_data_i,
    input  logic                    tx_v_i,
    output logic                    tx_ready_o,
    input  logic                    tx_drop_i,
    output logic [fifo_width_p-1:0] pkt_o,
    output logic                    pkt_v_o,
    input  logic                    pkt_ready_i,
    output logic [$clog2(fifo_width_p/host_width_p+1)-1:0] tx_vacancy_o,

    input  logic [fifo_width_p-1:0] pkt_i,
    input  logic                    pkt_v_i,
    output logic                    pkt_ready_o,
    output logic [host_width_p-1:0] rx_data_o,
    output logic                    rx_v_o,
    input  logic                    rx_yumi_i,
    output logic [$clog2(fifo_width_p/host_width_p+1)-1:0] rx_occupancy_o
);

    localparam int c_RATIO = fifo_width_p / host_width_p;
    localparam int c_CNT_W = $clog2(c_RATIO + 1);
    localparam logic [c_CNT_W-1:0] c_RATIO_CNT = c_CNT_W'(c_RATIO);
    localparam logic [c_CNT_W-1:0] c_LAST_IDX  = c_CNT_W'(c_RATIO - 1);

    if (c_RATIO < 2 || (fifo_width_p % host_width_p) != 0) begin : g_bad_ratio
        $error("gearbox needs fifo_width_p to be a multiple (>=2) of host_width_p");
    end

    // ---------------- TX path ----------------
    logic [fifo_width_p-1:0] r_tx_pkt;
    logic [c_CNT_W-1:0]      r_tx_idx;
    logic                    r_tx_full;
    logic                    w_tx_accept;
    logic                    w_tx_drop;

    // Drop only applies while assembling and takes priority over a word.
    assign w_tx_drop   = tx_drop_i & ~r_tx_full;
    assign w_tx_accept = tx_v_i & ~r_tx_full & ~tx_drop_i;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_tx_idx  <= '0;
            r_tx_full <= 1'b0;
        end else begin
            if (w_tx_drop) begin
                r_tx_idx <= '0;
            end else if (w_tx_accept) begin
                if (r_tx_idx == c_LAST_IDX) begin
                    r_tx_idx  <= '0;
                    r_tx_full <= 1'b1;
                end else begin
                    r_tx_idx <= r_tx_idx + 1'b1;
                end
            end else if (r_tx_full && pkt_ready_i) begin
                r_tx_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_tx_accept) begin
            r_tx_pkt[r_tx_idx*host_width_p +: host_width_p] <= tx_data_i;
        end
    end

    assign tx_ready_o   = ~r_tx_full;
    assign pkt_v_o      = r_tx_full;
    assign pkt_o        = r_tx_pkt;
    assign tx_vacancy_o = r_tx_full ? '0 : (c_RATIO_CNT - r_tx_idx);

    // ---------------- RX path ----------------
    logic [fifo_width_p-1:0] r_rx_pkt;
    logic [c_CNT_W-1:0]      r_rx_idx;
    logic                    r_rx_full;
    logic                    w_rx_load;

    assign w_rx_load = pkt_v_i & ~r_rx_full;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_rx_idx  <= '0;
            r_rx_full <= 1'b0;
        end else begin
            if (w_rx_load) begin
                r_rx_idx  <= '0;
                r_rx_full <= 1'b1;
            end else if (r_rx_full && rx_yumi_i) begin
                if (r_rx_idx == c_LAST_IDX) begin
                    r_rx_idx  <= '0;
                    r_rx_full <= 1'b0;
                end else begin
                    r_rx_idx <= r_rx_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_rx_load) begin
            r_rx_pkt <= pkt_i;
        end
    end

    assign pkt_ready_o    = ~r_rx_full;
    assign rx_v_o         = r_rx_full;
    assign rx_data_o      = r_rx_pkt[r_rx_idx*host_width_p +: host_width_p];
    assign rx_occupancy_o = r_rx_full ? (c_RATIO_CNT - r_rx_idx) : '0;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (reset_ni) begin
            assert (!(rx_yumi_i && !r_rx_full))
                else $error("rx_yumi_i asserted without rx_v_o");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_manycore_host_word_gearbox.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_manycore_host_word_gearbox
// Purpose  : Directed self-checking bench for the host word gearbox.
// Revision : 1.0
// ============================================================================
module tb_bsg_manycore_host_word_gearbox;

    logic         clk_i = 1'b0;
    logic         reset_ni;
    logic [31:0]  tx_data_i;
    logic         tx_v_i;
    logic         tx_ready_o;
    logic         tx_drop_i;
    logic [127:0] pkt_o;
    logic         pkt_v_o;
    logic         pkt_ready_i;
    logic [2:0]   tx_vacancy_o;
    logic [127:0] pkt_i;
    logic         pkt_v_i;
    logic         pkt_ready_o;
    logic [31:0]  rx_data_o;
    logic         rx_v_o;
    logic         rx_yumi_i;
    logic [2:0]   rx_occupancy_o;

    int total = 0;
    int bad   = 0;

    bsg_manycore_host_word_gearbox #(
        .fifo_width_p(128),
        .host_width_p(32)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .tx_data_i(tx_data_i), .tx_v_i(tx_v_i), .tx_ready_o(tx_ready_o),
        .tx_drop_i(tx_drop_i), .pkt_o(pkt_o), .pkt_v_o(pkt_v_o),
        .pkt_ready_i(pkt_ready_i), .tx_vacancy_o(tx_vacancy_o),
        .pkt_i(pkt_i), .pkt_v_i(pkt_v_i), .pkt_ready_o(pkt_ready_o),
        .rx_data_o(rx_data_o), .rx_v_o(rx_v_o), .rx_yumi_i(rx_yumi_i),
        .rx_occupancy_o(rx_occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".tx_ready"}, 128'(tx_ready_o), 128'd1);
        check({tag, ".pkt_v"}, 128'(pkt_v_o), 128'd0);
        check({tag, ".vacancy"}, 128'(tx_vacancy_o), 128'd4);
        check({tag, ".pkt_ready"}, 128'(pkt_ready_o), 128'd1);
        check({tag, ".rx_v"}, 128'(rx_v_o), 128'd0);
        check({tag, ".occupancy"}, 128'(rx_occupancy_o), 128'd0);
    endtask

    logic [127:0] p1;
    logic [127:0] p2;

    initial begin
        reset_ni = 1'b0; tx_data_i = '0; tx_v_i = 1'b0; tx_drop_i = 1'b0;
        pkt_ready_i = 1'b0; pkt_i = '0; pkt_v_i = 1'b0; rx_yumi_i = 1'b0;
        tick(); tick();
        check_reset_outputs("reset");
        reset_ni = 1'b1;
        tick();

        // Four back-to-back TX words with the bridge ready
        pkt_ready_i = 1'b1;
        tx_v_i = 1'b1; tx_data_i = 32'h11111111;
        check("t1.vac0", 128'(tx_vacancy_o), 128'd4);
        tick(); check("t1.vac1", 128'(tx_vacancy_o), 128'd3);
        tx_data_i = 32'h22222222;
        tick(); check("t1.vac2", 128'(tx_vacancy_o), 128'd2);
        tx_data_i = 32'h33333333;
        tick(); check("t1.vac3", 128'(tx_vacancy_o), 128'd1);
        check("t1.pkt_v_early", 128'(pkt_v_o), 128'd0);
        tx_data_i = 32'h44444444;
        tick();
        tx_v_i = 1'b0;
        check("t1.vac4", 128'(tx_vacancy_o), 128'd0);
        check("t1.pkt_v", 128'(pkt_v_o), 128'd1);
        check("t1.pkt", pkt_o, 128'h44444444_33333333_22222222_11111111);
        tick();
        check("t1.vac5", 128'(tx_vacancy_o), 128'd4);
        check("t1.pkt_v_clr", 128'(pkt_v_o), 128'd0);

        // Backpressured packet: stays stable, extra words ignored
        pkt_ready_i = 1'b0;
        tx_v_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_data_i = 32'hA0A0A0A0 + 32'(i);
            tick();
        end
        tx_data_i = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            check("t2.pkt_v", 128'(pkt_v_o), 128'd1);
            check("t2.tx_ready", 128'(tx_ready_o), 128'd0);
            check("t2.pkt", pkt_o, 128'hA0A0A0A3_A0A0A0A2_A0A0A0A1_A0A0A0A0);
            tick();
        end
        tx_v_i = 1'b0;
        pkt_ready_i = 1'b1;
        check("t2.tx_ready_comb", 128'(tx_ready_o), 128'd0);
        tick();
        check("t2.tx_ready_rel", 128'(tx_ready_o), 128'd1);
        check("t2.pkt_v_rel", 128'(pkt_v_o), 128'd0);

        // Drop with a simultaneous word, then a clean packet
        pkt_ready_i = 1'b0;
        tx_v_i = 1'b1;
        tx_data_i = 32'h55555555; tick();
        tx_data_i = 32'h66666666; tick();
        check("t3.vac_part", 128'(tx_vacancy_o), 128'd2);
        tx_data_i = 32'h77777777; tx_drop_i = 1'b1; tick();
        tx_drop_i = 1'b0;
        check("t3.vac_drop", 128'(tx_vacancy_o), 128'd4);
        for (int i = 1; i <= 4; i++) begin
            tx_data_i = 32'h01010101 * 32'(i);
            tick();
        end
        tx_v_i = 1'b0;
        check("t3.pkt_v", 128'(pkt_v_o), 128'd1);
        check("t3.pkt", pkt_o, 128'h04040404_03030303_02020202_01010101);
        tx_drop_i = 1'b1; tick(); tx_drop_i = 1'b0;
        check("t3.drop_full_ignored", 128'(pkt_v_o), 128'd1);
        pkt_ready_i = 1'b1; tick(); pkt_ready_i = 1'b0;

        // RX unpack with yumi held high
        p1 = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
        pkt_i = p1; pkt_v_i = 1'b1;
        check("t4.pkt_ready0", 128'(pkt_ready_o), 128'd1);
        tick();
        pkt_v_i = 1'b0;
        check("t4.rx_v", 128'(rx_v_o), 128'd1);
        check("t4.pkt_ready_busy", 128'(pkt_ready_o), 128'd0);
        rx_yumi_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t4.data", 128'(rx_data_o), 128'(p1[32*i +: 32]));
            check("t4.occ", 128'(rx_occupancy_o), 128'(4 - i));
            tick();
        end
        rx_yumi_i = 1'b0;
        check("t4.occ_end", 128'(rx_occupancy_o), 128'd0);
        check("t4.rx_v_end", 128'(rx_v_o), 128'd0);
        check("t4.pkt_ready_end", 128'(pkt_ready_o), 128'd1);

        // Second packet blocked while RX holds words
        pkt_i = 128'h44440004_33330003_22220002_11110001; pkt_v_i = 1'b1;
        p1 = pkt_i;
        tick();
        p2 = 128'h0F0F0F0F_0E0E0E0E_0D0D0D0D_0C0C0C0C;
        pkt_i = p2;
        rx_yumi_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t5.blocked", 128'(pkt_ready_o), 128'd0);
            check("t5.no_overwrite", 128'(rx_data_o), 128'(p1[32*i +: 32]));
            tick();
        end
        rx_yumi_i = 1'b0;
        check("t5.ready_after", 128'(pkt_ready_o), 128'd1);
        tick();
        pkt_v_i = 1'b0;
        check("t5.rx_v2", 128'(rx_v_o), 128'd1);
        check("t5.data2", 128'(rx_data_o), 128'h0C0C0C0C);
        check("t5.occ2", 128'(rx_occupancy_o), 128'd4);

        // Mid-cycle asynchronous reset with both paths busy
        rx_yumi_i = 1'b1; tick(); rx_yumi_i = 1'b0;
        tx_v_i = 1'b1; tx_data_i = 32'h12345678; tick(); tick();
        tx_v_i = 1'b0;
        check("t6.occ_pre", 128'(rx_occupancy_o), 128'd3);
        check("t6.vac_pre", 128'(tx_vacancy_o), 128'd2);
        #2;
        reset_ni = 1'b0;
        #1;
        check_reset_outputs("t6.async");
        tick();
        reset_ni = 1'b1;
        tick();
        check_reset_outputs("t6.after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
